dmem_store_buffer: RTL
======================

Name: dmem_store_buffer

Overview:
- In-order store buffer between the core's data-memory port and the data memory.
- Queues word stores issued by the MemAccess unit and drains them to memory over a req/ack handshake.
- Forwards the youngest matching buffered store to load reads, so loads see pending stores.
- Lets the core issue stores at full rate while memory write latency varies.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >= 2
ADDR_W, 32, address width (matches ADDR_LEN)
DATA_W, 32, data width (matches DATA_LEN)

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_i  in  1  synchronous, active-low reset
st_we_i  in  1  store request from core (dmem_we_o)
st_addr_i  in  ADDR_W  store address (dmem_waddr_o)
st_data_i  in  DATA_W  store data (dmem_wdata_o)
st_full_o  out  1  buffer holds DEPTH entries
ld_addr_i  in  ADDR_W  load address from core (dmem_raddr_o)
ld_data_o  out  DATA_W  load data to core (dmem_rdata_i)
mem_raddr_o  out  ADDR_W  read address to memory
mem_rdata_i  in  DATA_W  combinational read data from memory
mem_req_o  out  1  write request to memory
mem_waddr_o  out  ADDR_W  head entry address
mem_wdata_o  out  DATA_W  head entry data
mem_ack_i  in  1  memory accepted the head write this cycle
count_o  out  $clog2(DEPTH)+1  occupied entries
empty_o  out  1  count_o == 0
overflow_o  out  1  sticky: a store was dropped

Behaviour:
- Reset (reset_i == 0 at a rising edge):
  - head, tail and count go to 0; overflow_o goes to 0; all entry valid bits are cleared.
  - Outputs after reset: mem_req_o=0, st_full_o=0, empty_o=1, count_o=0.
  - mem_waddr_o and mem_wdata_o show entry 0 contents, which are don't-care while mem_req_o=0.
  - Reset overrides every simultaneous event, including a pending ack and an incoming store.
  - Reset mid-drain discards the queued stores. No write is issued after reset.
- Circular FIFO:
  - head and tail are $clog2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - Occupancy comes from count, not from pointer equality.
- Dequeue:
  - pop = mem_req_o & mem_ack_i.
  - On pop, head advances at the edge.
- Enqueue:
  - push = st_we_i & (count < DEPTH | pop).
  - On push, {st_addr_i, st_data_i} is written at tail and tail advances.
  - A full buffer accepts a store in the same cycle it pops. count stays DEPTH and both pointers advance.
- Count update:
  - count_next = count + push - pop.
  - Never exceeds DEPTH and never underflows.
- Overflow:
  - st_we_i & count == DEPTH & !pop drops the store.
  - The drop sets overflow_o, which stays set until reset. Contents are unchanged.
- Drain handshake:
  - mem_req_o = !empty, combinational from registered count.
  - mem_waddr_o and mem_wdata_o = head entry.
  - Request, address and data hold stable until the ack cycle.
  - mem_ack_i while mem_req_o=0 is ignored.
  - Back-to-back acks drain one entry per cycle.
- Latency:
  - A store accepted at edge N appears on the memory port no earlier than the cycle after edge N.
  - It drains in FIFO order.
  - Minimum store-to-memory latency is 1 cycle with ack tied high.
- Load forwarding (combinational):
  - mem_raddr_o = ld_addr_i.
  - ld_data_o = data of the youngest valid entry whose address equals ld_addr_i exactly, full ADDR_W compare, word granularity. Otherwise ld_data_o = mem_rdata_i.
  - "Youngest" means closest to tail, searched backwards from tail-1 through head.
  - An entry being popped in the current cycle is still forwarded.
  - A store arriving on st_we_i in the same cycle is not forwarded; the next cycle sees it.
- Status outputs: st_full_o = (count == DEPTH), empty_o and count_o are all driven from registered state, so they are glitch-free.

Test Plan:
- Reset then idle:
  - Hold reset_i=0 for 2 cycles, then release.
  - Expect mem_req_o=0, empty_o=1, count_o=0, overflow_o=0, and ld_data_o tracking mem_rdata_i (drive 0xDEADBEEF -> read 0xDEADBEEF).
- Single store with delayed ack:
  - Store 0x11223344 to 0x100; hold mem_ack_i=0 for 3 cycles, then pulse it.
  - Expect mem_req_o high the cycle after the store, mem_waddr_o=0x100 and mem_wdata_o=0x11223344 stable for 4 cycles, then empty_o=1.
- Fill and overflow:
  - With ack=0, issue 5 stores to 0x0, 0x4, 0x8, 0xC, 0x10.
  - Expect st_full_o=1 after the 4th store, 0x10 dropped, overflow_o=1.
  - Release ack=1: drains exactly 0x0, 0x4, 0x8, 0xC in order; overflow_o stays 1.
- Push while full with pop:
  - Buffer full and ack=1 in the same cycle as a store to 0x20.
  - Expect count_o stays 4, no overflow, and 0x20 drains last after pointer wrap-around.
- Forwarding youngest match:
  - With ack=0, store A to 0x40, B to 0x44, C to 0x40; read 0x40 -> C.
  - Read 0x44 -> B; read 0x48 -> mem_rdata_i.
  - A load in the cycle of a new store to 0x48 still returns mem_rdata_i.
- Reset mid-drain:
  - 3 entries queued, ack high; assert reset_i=0 for one cycle.
  - Expect no further mem_req_o, count_o=0, and load of a previously buffered address returns mem_rdata_i.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   In-order store buffer between the core data-memory port and data memory.
//   Word stores are queued in a circular FIFO. They drain to memory over a
//   req/ack handshake. Loads are forwarded from the youngest matching
//   buffered store.
//
// Ports
//   clk_i        clock, rising edge
//   reset_i      synchronous active-low reset
//   st_we_i      store request from core
//   st_addr_i    store address
//   st_data_i    store data
//   st_full_o    buffer holds DEPTH entries
//   ld_addr_i    load address from core
//   ld_data_o    load data to core (forwarded or from memory)
//   mem_raddr_o  read address to memory (= ld_addr_i)
//   mem_rdata_i  combinational read data from memory
//   mem_req_o    write request (buffer not empty)
//   mem_waddr_o  head entry address
//   mem_wdata_o  head entry data
//   mem_ack_i    memory accepted the head write this cycle
//   count_o      occupied entries
//   empty_o      count_o == 0
//   overflow_o   sticky: a store was dropped
module dmem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       st_we_i,
    input  logic [ADDR_W-1:0]          st_addr_i,
    input  logic [DATA_W-1:0]          st_data_i,
    output logic                       st_full_o,
    input  logic [ADDR_W-1:0]          ld_addr_i,
    output logic [DATA_W-1:0]          ld_data_o,
    output logic [ADDR_W-1:0]          mem_raddr_o,
    input  logic [DATA_W-1:0]          mem_rdata_i,
    output logic                       mem_req_o,
    output logic [ADDR_W-1:0]          mem_waddr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    input  logic                       mem_ack_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ADDR_W-1:0] r_addr  [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [PW-1:0]     w_idx;
    logic [DATA_W-1:0] w_ld_data;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && mem_ack_i;
    // A full buffer still accepts a store in a cycle that frees the head slot.
    assign w_push  = st_we_i && (!w_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_valid    <= '0;
        end else begin
            // Clear before set: when full with push and pop, head == tail
            // and the incoming store must own the slot.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push) begin
                r_addr[r_tail]  <= st_addr_i;
                r_data[r_tail]  <= st_data_i;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (st_we_i && w_full && !w_pop)
                r_overflow <= 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Walk the entries oldest to youngest so the youngest match wins.
    // Only entries in [head, tail) carry a valid bit.
    always_comb begin
        w_ld_data = mem_rdata_i;
        w_idx     = r_head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (r_valid[w_idx] && (r_addr[w_idx] == ld_addr_i))
                w_ld_data = r_data[w_idx];
        end
    end

    assign ld_data_o   = w_ld_data;
    assign mem_raddr_o = ld_addr_i;
    assign mem_req_o   = !w_empty;
    assign mem_waddr_o = r_addr[r_head];
    assign mem_wdata_o = r_data[r_head];
    assign st_full_o   = w_full;
    assign empty_o     = w_empty;
    assign count_o     = r_count;
    assign overflow_o  = r_overflow;

endmodule
